// File: rtl/ekg_sample_receiver_if.sv
// Sample stream bundle between the ECG generator, the receiver FIFO and the downstream filter.
// master = stream driver/consumer side (generator + filter), slave = the receiver itself.
interface ekg_sample_receiver_if #(
  parameter int DATA_W = 24
);
  logic signed [DATA_W-1:0] data_in;
  logic                     data_in_valid;
  logic        [DATA_W-1:0] data_out;
  logic                     data_out_valid;
  logic                     data_out_ready;

  modport master (
    output data_in,
    output data_in_valid,
    output data_out_ready,
    input  data_out,
    input  data_out_valid
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    input  data_out_ready,
    output data_out,
    output data_out_valid
  );
endinterface

// File: rtl/ekg_sample_receiver.sv
// Show-ahead circular sample FIFO with sticky overflow between the ECG generator and the filter.
// Optional build macro DROP_COUNT_EN adds a saturating 16-bit dropped-sample counter port.
module ekg_sample_receiver #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  ekg_sample_receiver_if.slave     bus,
  input  logic                     overflow_clr_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]              drop_count_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic              armed_q;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic empty;
  logic full;
  logic rd_en;
  logic wr_en;
  logic drop;

  // armed_q blocks writes on the first edge after reset release
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    rd_en = !empty && bus.data_out_ready;
    wr_en = armed_q && bus.data_in_valid && (!full || rd_en);
    drop  = armed_q && bus.data_in_valid && full && !rd_en;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) begin
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (rd_en) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  // a drop in the same cycle as a clear wins
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      armed_q    <= 1'b1;
      overflow_q <= overflow_d;
    end
  end

  // storage is not reset; contents are only visible through valid read pointers
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= bus.data_in;
    end
  end

  assign bus.data_out       = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign bus.data_out_valid = !empty;
  assign level_o            = wptr_q - rptr_q;
  assign overflow_o         = overflow_q;

`ifdef DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr_i) begin
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: doc/ekg_sample_receiver.md
EKG_SAMPLE_RECEIVER -- requirements
Module: ekg_sample_receiver

Interface
REQ-001 Parameter DATA_W, default 24, sample width in bits.
REQ-002 Parameter DEPTH, default 16, buffer depth in samples; power of two, 4..256.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 data_in  input  DATA_W  signed sample from the ECG generator.
REQ-006 data_in_valid  input  1  one-cycle strobe; data_in is valid in that cycle.
REQ-007 data_out  output  DATA_W  oldest buffered sample (show-ahead).
REQ-008 data_out_valid  output  1  data_out holds a valid sample.
REQ-009 data_out_ready  input  1  downstream filter accepts data_out this cycle.
REQ-010 level  output  $clog2(DEPTH)+1  number of samples buffered.
REQ-011 overflow  output  1  sticky flag; at least one sample was dropped.
REQ-012 overflow_clr  input  1  synchronous clear of overflow (and drop_count when present).

Function
REQ-013 The block SHALL buffer incoming samples in a circular FIFO of DEPTH entries with separate read and write pointers one bit wider than the address.
REQ-014 A write SHALL occur when data_in_valid=1 and (FIFO not full, or a read occurs in the same cycle).
REQ-015 A read SHALL occur when data_out_valid=1 and data_out_ready=1.
REQ-016 Write-to-output latency SHALL be 1 cycle: a sample written into an empty FIFO SHALL appear on data_out with data_out_valid=1 on the next rising edge.
REQ-017 data_out SHALL stay stable while data_out_valid=1 and data_out_ready=0.
REQ-018 Full (level=DEPTH) with data_in_valid=1 and no read SHALL drop the sample, leave the FIFO unchanged, and set overflow on the next edge.
REQ-019 Full with simultaneous write and read SHALL accept the new sample; level stays DEPTH; overflow is not set.
REQ-020 Empty with data_out_ready=1 SHALL not change pointers or level.
REQ-021 Simultaneous write and read at level 1..DEPTH-1 SHALL leave level unchanged.
REQ-022 Pointers SHALL wrap modulo 2*DEPTH; full = addresses equal and MSBs differ, empty = pointers equal.
REQ-023 overflow_clr=1 SHALL clear overflow; if a drop occurs in the same cycle, the set SHALL take priority.
REQ-024 Sample data SHALL pass unmodified, bit-exact.

Reset
REQ-025 While reset=0, the block SHALL clear pointers, set level=0, data_out_valid=0, data_out=0, overflow=0 and drop_count=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered samples immediately; the first sample after release SHALL be the first one output.
REQ-027 The block SHALL ignore data_in_valid during the cycle in which reset is released.

Configuration
REQ-028 Macro DROP_COUNT_EN: when defined, the block SHALL add output port drop_count (16 bits), incremented per dropped sample, saturating at 0xFFFF, cleared by overflow_clr (an increment in the same cycle as overflow_clr SHALL yield 1).
REQ-029 Without DROP_COUNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset held 100 ns, then strobe samples 0x000001..0x000003 with ready=1 -> data_out sequence 0x000001, 0x000002, 0x000003, each 1 cycle after its strobe; level never exceeds 1.
REQ-031 ready=0, write 16 samples 0x100000..0x10000F, write 0x7FFFFF -> level=16, overflow=1, drop_count=1; then ready=1 -> outputs 0x100000..0x10000F in order, 0x7FFFFF never appears.
REQ-032 Full FIFO, data_in_valid=1 and ready=1 in the same cycle with 0x800000 -> level stays 16, overflow stays 0, 0x800000 is output last.
REQ-033 Level 5, reset pulled low for 1 cycle -> level=0, data_out_valid=0 immediately; next sample 0x0000AA is the first output.
REQ-034 Overflow set, overflow_clr=1 concurrent with another drop -> overflow remains 1, drop_count=1 (DROP_COUNT_EN build).
REQ-035 Random valid/ready patterns over 10,000 samples from the ECG generator with 24-bit data -> scoreboard shows every non-dropped sample output exactly once, in order.
